// File: rtl/usb_fs_in_pe_pp_if.sv
// usb_fs_in_pe_pp_if: rx/tx packet-layer bus between the USB packet layer and the IN protocol engine
//   rx_*  : received packet strobes and decoded fields (packet layer -> engine)
//   tx_*  : handshake/data packet request and payload stream (engine <-> packet layer)
//   master: packet layer side, slave: protocol engine side
interface usb_fs_in_pe_pp_if;
  logic        rx_pkt_start;
  logic        rx_pkt_end;
  logic        rx_pkt_valid;
  logic [3:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [10:0] rx_frame_num;
  logic        tx_pkt_start;
  logic        tx_pkt_end;
  logic [3:0]  tx_pid;
  logic        tx_data_avail;
  logic        tx_data_get;
  logic [7:0]  tx_data;
  modport master (
    output rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp, rx_frame_num,
    output tx_pkt_end, tx_data_get,
    input  tx_pkt_start, tx_pid, tx_data_avail, tx_data
  );
  modport slave (
    input  rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp, rx_frame_num,
    input  tx_pkt_end, tx_data_get,
    output tx_pkt_start, tx_pid, tx_data_avail, tx_data
  );
endinterface

// File: rtl/usb_fs_in_pe_pp.sv
// usb_fs_in_pe_pp: double-buffered (ping-pong) USB full-speed IN protocol engine
//   clk, reset_n        : 48 MHz clock, asynchronous active-low reset
//   reset_ep            : per-endpoint synchronous flush
//   dev_addr            : assigned device address
//   in_ep_data_*        : endpoint fill side (free / put / data / done)
//   in_ep_stall         : level STALL request, latched until SETUP
//   in_ep_acked         : one-cycle pulse when the host ACKs a packet
//   bus                 : rx token/handshake strobes and tx packet stream
module usb_fs_in_pe_pp #(
  parameter int NUM_IN_EPS = 4,
  parameter int MAX_IN_PACKET_SIZE = 64,
  parameter int ACK_TIMEOUT = 96
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IN_EPS-1:0] reset_ep,
  input  logic [6:0]            dev_addr,
  output logic [NUM_IN_EPS-1:0] in_ep_data_free,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
  input  logic [7:0]            in_ep_data,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
  input  logic [NUM_IN_EPS-1:0] in_ep_stall,
  output logic [NUM_IN_EPS-1:0] in_ep_acked,
  usb_fs_in_pe_pp_if.slave      bus
);
  localparam int N = NUM_IN_EPS;
  localparam int AW = $clog2(MAX_IN_PACKET_SIZE);
  localparam int EW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RCVD_IN, SEND_DATA, WAIT_ACK} state_t;
  state_t state, state_d;
  logic [7:0] buffer [2**(EW+1+AW)];
  logic [N-1:0] wr_bank, wr_bank_d, rd_bank, rd_bank_d, toggle, toggle_d, stalled, stalled_d;
  logic [N-1:0] free_d, acked_d, put_ok, done_ok, commit;
  logic [N-1:0][1:0] full, full_d;
  logic [N-1:0][1:0][AW:0] len, len_d;
  logic [N-1:0][AW:0] wr_cnt, wr_cnt_d;
  logic [EW-1:0] cur_ep;
  logic [AW:0] rd_ptr, rd_ptr_d;
  logic [7:0] to_cnt;
  logic [3:0] pid_q, resp_pid;
  logic tok, in_tok, setup_tok, ack, avail, wr_en;
  logic [EW+AW:0] wr_addr, rd_addr;
  logic unused;
  assign unused = ^{bus.rx_pkt_start, bus.rx_frame_num};
  assign tok = bus.rx_pkt_end && bus.rx_pkt_valid && bus.rx_pid[1:0] == 2'b01 &&
               bus.rx_addr == dev_addr && {28'd0, bus.rx_endp} < 32'(N);
  assign in_tok = tok && bus.rx_pid == 4'b1001;
  assign setup_tok = tok && bus.rx_pid == 4'b1101;
  assign ack = bus.rx_pkt_end && bus.rx_pkt_valid && bus.rx_pid == 4'b0010;
  // Per-endpoint bank bookkeeping; later statements override earlier ones (flush wins).
  always_comb begin
    put_ok = in_ep_data_put & in_ep_data_free;
    done_ok = in_ep_data_done & in_ep_data_free;
    wr_bank_d = wr_bank;
    rd_bank_d = rd_bank;
    toggle_d = toggle;
    stalled_d = stalled | in_ep_stall;
    full_d = full;
    len_d = len;
    wr_cnt_d = wr_cnt;
    commit = '0;
    acked_d = '0;
    free_d = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    for (int i = 0; i < N; i++) begin
      commit[i] = done_ok[i] || (put_ok[i] && wr_cnt[i] == (AW+1)'(MAX_IN_PACKET_SIZE - 1));
      if (put_ok[i]) begin
        wr_en = 1'b1;
        wr_addr = {EW'(i), wr_bank[i], wr_cnt[i][AW-1:0]};
        wr_cnt_d[i] = wr_cnt[i] + (AW+1)'(1);
      end
      if (commit[i]) begin
        full_d[i][wr_bank[i]] = 1'b1;
        len_d[i][wr_bank[i]] = wr_cnt_d[i];
        wr_bank_d[i] = ~wr_bank[i];
        wr_cnt_d[i] = '0;
      end
      acked_d[i] = state == WAIT_ACK && ack && cur_ep == EW'(i);
      if (acked_d[i]) begin
        full_d[i][rd_bank[i]] = 1'b0;
        rd_bank_d[i] = ~rd_bank[i];
        toggle_d[i] = ~toggle[i];
      end
      if (setup_tok && bus.rx_endp == 4'(i)) begin
        full_d[i] = '0;
        wr_cnt_d[i] = '0;
        wr_bank_d[i] = 1'b0;
        rd_bank_d[i] = 1'b0;
        toggle_d[i] = 1'b1;
        stalled_d[i] = in_ep_stall[i];
      end
      if (reset_ep[i]) begin
        full_d[i] = '0;
        wr_cnt_d[i] = '0;
        wr_bank_d[i] = 1'b0;
        rd_bank_d[i] = 1'b0;
        toggle_d[i] = 1'b0;
        stalled_d[i] = 1'b0;
      end
      free_d[i] = !full_d[i][wr_bank_d[i]] && !stalled_d[i];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = in_tok ? RCVD_IN : IDLE;
      RCVD_IN:   state_d = !stalled[cur_ep] && full[cur_ep][rd_bank[cur_ep]] ? SEND_DATA : IDLE;
      SEND_DATA: state_d = bus.tx_pkt_end ? WAIT_ACK : SEND_DATA;
      WAIT_ACK:  state_d = ack ? IDLE : in_tok ? RCVD_IN :
                           (bus.rx_pkt_end || to_cnt == 8'(ACK_TIMEOUT)) ? IDLE : WAIT_ACK;
      default:   state_d = IDLE;
    endcase
    if (state != IDLE && reset_ep[cur_ep]) state_d = IDLE;
  end
  always_comb begin
    resp_pid = stalled[cur_ep] ? 4'b1110 :
               full[cur_ep][rd_bank[cur_ep]] ? {toggle[cur_ep], 3'b011} : 4'b1010;
    avail = state == SEND_DATA && rd_ptr < len[cur_ep][rd_bank[cur_ep]];
    bus.tx_pkt_start = state == RCVD_IN;
    bus.tx_pid = state == RCVD_IN ? resp_pid : pid_q;
    bus.tx_data_avail = avail;
  end
  // Read address follows the next pointer so tx_data is ready the cycle after a get.
  assign rd_ptr_d = state == SEND_DATA ? rd_ptr + (AW+1)'(bus.tx_data_get && avail) : '0;
  assign rd_addr = {cur_ep, rd_bank[cur_ep], rd_ptr_d[AW-1:0]};
  always_ff @(posedge clk)
    if (wr_en) buffer[wr_addr] <= in_ep_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_bank <= '0;
      rd_bank <= '0;
      toggle <= '0;
      stalled <= '0;
      full <= '0;
      len <= '0;
      wr_cnt <= '0;
      cur_ep <= '0;
      rd_ptr <= '0;
      to_cnt <= '0;
      pid_q <= '0;
      bus.tx_data <= '0;
      in_ep_data_free <= '0;
      in_ep_acked <= '0;
    end else begin
      wr_bank <= wr_bank_d;
      rd_bank <= rd_bank_d;
      toggle <= toggle_d;
      stalled <= stalled_d;
      full <= full_d;
      len <= len_d;
      wr_cnt <= wr_cnt_d;
      cur_ep <= in_tok ? bus.rx_endp[EW-1:0] : cur_ep;
      rd_ptr <= rd_ptr_d;
      to_cnt <= state == WAIT_ACK ? to_cnt + 8'd1 : 8'd0;
      pid_q <= state == RCVD_IN ? resp_pid : pid_q;
      bus.tx_data <= buffer[rd_addr];
      in_ep_data_free <= free_d;
      in_ep_acked <= acked_d;
    end
endmodule

// File: tb/tb_usb_fs_in_pe_pp.sv
// tb_usb_fs_in_pe_pp: directed table-driven bench for the ping-pong USB IN protocol engine
module tb_usb_fs_in_pe_pp;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] reset_ep = '0;
  logic [6:0] dev_addr = 7'd5;
  logic [3:0] in_ep_data_free;
  logic [3:0] in_ep_data_put = '0;
  logic [7:0] in_ep_data = '0;
  logic [3:0] in_ep_data_done = '0;
  logic [3:0] in_ep_stall = '0;
  logic [3:0] in_ep_acked;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got[$];
  typedef struct {
    int         ep;
    int         n;
    logic [7:0] base;
    logic [3:0] pid;
  } vec_t;
  vec_t vt[8];
  usb_fs_in_pe_pp_if bus();
  usb_fs_in_pe_pp #(.NUM_IN_EPS(4), .MAX_IN_PACKET_SIZE(64), .ACK_TIMEOUT(96)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .reset_ep(reset_ep),
    .dev_addr(dev_addr),
    .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall),
    .in_ep_acked(in_ep_acked),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    bus.rx_pid = pid;
    bus.rx_addr = addr;
    bus.rx_endp = ep;
    bus.rx_pkt_end = 1'b1;
    bus.rx_pkt_valid = 1'b1;
    tick();
    bus.rx_pkt_end = 1'b0;
    bus.rx_pkt_valid = 1'b0;
  endtask
  task automatic fill(input int ep, input int n, input logic [7:0] base, input bit commit);
    for (int j = 0; j < n; j++) begin
      in_ep_data_put = 4'(1 << ep);
      in_ep_data = base + 8'(j);
      tick();
    end
    in_ep_data_put = '0;
    if (commit) begin
      in_ep_data_done = 4'(1 << ep);
      tick();
      in_ep_data_done = '0;
    end
  endtask
  task automatic in_req(input int ep, input logic [3:0] pid, input string name);
    send_tok(4'b1001, 7'd5, 4'(ep));
    chk({name, " tx_pkt_start"}, 64'(bus.tx_pkt_start), 64'd1);
    chk({name, " tx_pid"}, 64'(bus.tx_pid), 64'(pid));
    tick();
  endtask
  task automatic drain(input string name);
    got.delete();
    if (bus.tx_data_avail) got.push_back(bus.tx_data);
    for (int g = 0; g < 200 && bus.tx_data_avail; g++) begin
      bus.tx_data_get = 1'b1;
      tick();
      bus.tx_data_get = 1'b0;
      if (!bus.tx_data_avail) break;
      got.push_back(bus.tx_data);
      tick();
    end
    chk({name, " avail low at end"}, 64'(bus.tx_data_avail), 64'd0);
    bus.tx_pkt_end = 1'b1;
    tick();
    bus.tx_pkt_end = 1'b0;
  endtask
  task automatic chk_payload(input string name, input int n, input logic [7:0] base);
    logic [7:0] e;
    chk({name, " length"}, 64'(got.size()), 64'(n));
    for (int j = 0; j < got.size() && j < n; j++) begin
      e = base + 8'(j);
      chk($sformatf("%s byte%0d", name, j), 64'(got[j]), 64'(e));
    end
  endtask
  task automatic do_ack(input logic [3:0] exp, input string name);
    send_tok(4'b0010, 7'd0, 4'd0);
    chk({name, " in_ep_acked"}, 64'(in_ep_acked), 64'(exp));
  endtask
  task automatic chk_idle_outputs(input string name);
    chk({name, " tx_pkt_start"}, 64'(bus.tx_pkt_start), 64'd0);
    chk({name, " tx_pid"}, 64'(bus.tx_pid), 64'd0);
    chk({name, " tx_data"}, 64'(bus.tx_data), 64'd0);
    chk({name, " tx_data_avail"}, 64'(bus.tx_data_avail), 64'd0);
    chk({name, " in_ep_acked"}, 64'(in_ep_acked), 64'd0);
    chk({name, " in_ep_data_free"}, 64'(in_ep_data_free), 64'd0);
  endtask
  initial begin
    vt[0] = '{ep: 1, n: 3,  base: 8'hA1, pid: 4'b0011};
    vt[1] = '{ep: 1, n: 1,  base: 8'h55, pid: 4'b1011};
    vt[2] = '{ep: 2, n: 0,  base: 8'h00, pid: 4'b0011};
    vt[3] = '{ep: 0, n: 64, base: 8'h00, pid: 4'b0011};
    vt[4] = '{ep: 0, n: 8,  base: 8'h40, pid: 4'b1011};
    vt[5] = '{ep: 3, n: 5,  base: 8'hC0, pid: 4'b0011};
    vt[6] = '{ep: 1, n: 2,  base: 8'h10, pid: 4'b0011};
    vt[7] = '{ep: 2, n: 1,  base: 8'h77, pid: 4'b1011};
    bus.rx_pkt_start = 1'b0;
    bus.rx_pkt_end = 1'b0;
    bus.rx_pkt_valid = 1'b0;
    bus.rx_pid = '0;
    bus.rx_addr = '0;
    bus.rx_endp = '0;
    bus.rx_frame_num = '0;
    bus.tx_pkt_end = 1'b0;
    bus.tx_data_get = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();
    chk("free after release", 64'(in_ep_data_free), 64'hF);
    for (int r = 0; r < 8; r++) begin
      fill(vt[r].ep, vt[r].n, vt[r].base, vt[r].n != 64);
      in_req(vt[r].ep, vt[r].pid, $sformatf("row%0d", r));
      drain($sformatf("row%0d", r));
      chk_payload($sformatf("row%0d", r), vt[r].n, vt[r].base);
      do_ack(4'(1 << vt[r].ep), $sformatf("row%0d", r));
      tick();
      chk($sformatf("row%0d acked pulse ends", r), 64'(in_ep_acked), 64'd0);
    end
    fill(0, 64, 8'h00, 1'b0);
    fill(0, 10, 8'h80, 1'b1);
    chk("ep0 free after 2nd commit", 64'(in_ep_data_free[0]), 64'd0);
    fill(0, 1, 8'hEE, 1'b0);
    chk("ep0 free after ignored put", 64'(in_ep_data_free[0]), 64'd0);
    in_req(0, 4'b0011, "ep0 64");
    drain("ep0 64");
    chk_payload("ep0 64", 64, 8'h00);
    do_ack(4'b0001, "ep0 64");
    chk("ep0 free after ack", 64'(in_ep_data_free[0]), 64'd1);
    tick();
    in_req(0, 4'b1011, "ep0 10");
    drain("ep0 10");
    chk_payload("ep0 10", 10, 8'h80);
    do_ack(4'b0001, "ep0 10");
    tick();
    fill(2, 4, 8'h30, 1'b1);
    in_req(2, 4'b0011, "ep2 first");
    drain("ep2 first");
    chk_payload("ep2 first", 4, 8'h30);
    repeat (100) tick();
    do_ack(4'b0000, "ep2 late ack");
    tick();
    in_req(2, 4'b0011, "ep2 resend");
    drain("ep2 resend");
    chk_payload("ep2 resend", 4, 8'h30);
    repeat (90) tick();
    do_ack(4'b0100, "ep2 ack in time");
    tick();
    in_ep_stall = 4'b1000;
    tick();
    in_ep_stall = '0;
    chk("ep3 free while stalled", 64'(in_ep_data_free[3]), 64'd0);
    in_req(3, 4'b1110, "ep3 stall");
    in_req(3, 4'b1110, "ep3 stall held");
    send_tok(4'b1101, 7'd5, 4'd3);
    chk("ep3 free after setup", 64'(in_ep_data_free[3]), 64'd1);
    in_req(3, 4'b1010, "ep3 nak after setup");
    fill(3, 2, 8'hD0, 1'b1);
    in_req(3, 4'b1011, "ep3 data1");
    drain("ep3 data1");
    chk_payload("ep3 data1", 2, 8'hD0);
    do_ack(4'b1000, "ep3 data1");
    tick();
    fill(1, 1, 8'h11, 1'b1);
    reset_ep = 4'b0010;
    tick();
    reset_ep = '0;
    in_req(1, 4'b1010, "ep1 nak after reset_ep");
    fill(1, 1, 8'h99, 1'b1);
    in_req(1, 4'b0011, "ep1 data0 after reset_ep");
    drain("ep1 after reset_ep");
    chk_payload("ep1 after reset_ep", 1, 8'h99);
    do_ack(4'b0010, "ep1 after reset_ep");
    tick();
    send_tok(4'b1001, 7'd6, 4'd0);
    chk("wrong addr no response", 64'(bus.tx_pkt_start), 64'd0);
    tick();
    send_tok(4'b1001, 7'd5, 4'd4);
    chk("bad endpoint no response", 64'(bus.tx_pkt_start), 64'd0);
    tick();
    fill(0, 3, 8'h61, 1'b1);
    in_req(0, 4'b0011, "ep0 before reset");
    chk("ep0 avail before reset", 64'(bus.tx_data_avail), 64'd1);
    chk("ep0 first byte before reset", 64'(bus.tx_data), 64'h61);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    tick();
    reset_n = 1'b1;
    tick();
    chk("free after second release", 64'(in_ep_data_free), 64'hF);
    in_req(0, 4'b1010, "ep0 nak after reset");
    in_req(2, 4'b1010, "ep2 nak after reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
